// File: rtl/dds_pkg.sv
// dds_pkg: shared definitions for the DDS phase generator.
//   - quadrant encoding of the two phase MSBs
//   - quarter-wave ROM geometry helpers
//   - dither LFSR seed and tap mask (used only when DDS_DITHER_EN is defined)
package dds_pkg;

  // The two MSBs of the phase select one quarter of the sine period.
  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,  // rising, positive
    QUAD_1 = 2'd1,  // falling, positive  (mirrored address)
    QUAD_2 = 2'd2,  // falling, negative
    QUAD_3 = 2'd3   // rising, negative   (mirrored address)
  } quad_e;

  localparam int          LFSR_W    = 16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 mapped onto bit indices 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Quarter ROM address width: two full-wave bits are spent on the quadrant.
  function automatic int rom_addr_w(input int lut_addr_w);
    return lut_addr_w - 2;
  endfunction

  function automatic int rom_depth(input int lut_addr_w);
    return 1 << (lut_addr_w - 2);
  endfunction

  // Quadrants 1 and 3 walk the quarter table backwards.
  function automatic logic quad_mirrored(input quad_e q);
    return (q == QUAD_1) || (q == QUAD_3);
  endfunction

  // Quadrants 2 and 3 are the negative half of the period.
  function automatic logic quad_negative(input quad_e q);
    return (q == QUAD_2) || (q == QUAD_3);
  endfunction

endpackage

// File: rtl/dds_sine_rom.sv
// dds_sine_rom: quarter-wave sine table with one registered read port.
// The table is generated at elaboration; entry i holds
//   round((2^(DATA_W-1)-1) * sin(2*pi*(i+0.5)/2^FULL_ADDR_W))
// The half-step offset keeps all four quadrants exactly symmetric, and since
// the largest magnitude is 2^(DATA_W-1)-1, negation downstream cannot overflow.
// Ports:
//   clk   in   system clock
//   rstn  in   synchronous active-low reset (clears the read register)
//   addr  in   quarter-table index, ADDR_W bits
//   data  out  registered signed sample magnitude, DATA_W bits
module dds_sine_rom
  import dds_pkg::*;
#(
  parameter int FULL_ADDR_W = 10,
  parameter int DATA_W      = 12,
  parameter int ADDR_W      = rom_addr_w(FULL_ADDR_W)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  localparam int  DEPTH = 1 << ADDR_W;
  localparam real PI    = 3.14159265358979323846;

  // Round half away from zero.
  function automatic logic signed [DATA_W-1:0] round_to_int(input real x);
    if (x >= 0.0) begin
      return DATA_W'($rtoi(x + 0.5));
    end
    return DATA_W'(-$rtoi(-x + 0.5));
  endfunction

  function automatic logic signed [DATA_W-1:0] rom_entry(input int i);
    real ang;
    real amp;
    ang = 2.0 * PI * (real'(i) + 0.5) / real'(1 << FULL_ADDR_W);
    amp = real'((1 << (DATA_W - 1)) - 1);
    return round_to_int(amp * $sin(ang));
  endfunction

  logic signed [DATA_W-1:0] rom_tbl [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    assign rom_tbl[gi] = rom_entry(gi);
  end

  logic signed [DATA_W-1:0] data_p2;

  // ---- stage S2: registered table read ----
  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_p2 <= '0;
    end else begin
      data_p2 <= rom_tbl[addr];
    end
  end

  assign data = data_p2;

endmodule

// File: rtl/dds_phase_gen.sv
// dds_phase_gen: 32-bit DDS phase accumulator followed by a quarter-wave
// sine lookup. Takes its tuning word from the SPI configuration block and
// drives the DAC/mixer path.
// Optional build macro: DDS_DITHER_EN adds a 16-bit LFSR to the lookup
// address (never to phase_out) to spread phase-truncation spurs.
// Ports:
//   clk           in   system clock
//   rstn          in   synchronous active-low reset
//   param_wen     in   one-cycle strobe, phase_fword valid this cycle
//   phase_fword   in   frequency tuning word, PHASE_WIDTH bits
//   en            in   accumulator advance enable
//   sync_clr      in   synchronous phase clear (priority over en)
//   phase_out     out  current accumulator value
//   sample_out    out  signed sine sample, AMP_WIDTH bits
//   sample_valid  out  sample_out comes from an enabled accumulator step
//   fword_active  out  tuning word currently applied by the accumulator
// Latency: accumulator value after edge N reaches sample_out after edge N+3.
module dds_phase_gen
  import dds_pkg::*;
#(
  parameter int PHASE_WIDTH    = 32,
  parameter int LUT_ADDR_WIDTH = 10,
  parameter int AMP_WIDTH      = 12
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   param_wen,
  input  logic [PHASE_WIDTH-1:0] phase_fword,
  input  logic                   en,
  input  logic                   sync_clr,
  output logic [PHASE_WIDTH-1:0] phase_out,
  output logic [AMP_WIDTH-1:0]   sample_out,
  output logic                   sample_valid,
  output logic [PHASE_WIDTH-1:0] fword_active
);

  localparam int ROM_AW = rom_addr_w(LUT_ADDR_WIDTH);

  function automatic logic signed [AMP_WIDTH-1:0] apply_sign(
    input logic signed [AMP_WIDTH-1:0] mag,
    input logic                        neg
  );
    // Table magnitudes never reach -2^(AMP_WIDTH-1), so this cannot wrap.
    return neg ? -mag : mag;
  endfunction

  logic [PHASE_WIDTH-1:0] fword_q;
  logic [PHASE_WIDTH-1:0] acc_p0;
  logic                   vld_p0;

  // The add below reads fword_q before this edge's update, so a word loaded
  // together with en takes effect one step later.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fword_q <= '0;
    end else if (param_wen) begin
      fword_q <= phase_fword;
    end
  end

  // ---- stage S0: phase accumulator ----
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_p0 <= '0;
      vld_p0 <= 1'b0;
    end else begin
      if (sync_clr) begin
        acc_p0 <= '0;
      end else if (en) begin
        acc_p0 <= acc_p0 + fword_q;
      end
      vld_p0 <= en & ~sync_clr;
    end
  end

  // Top LUT_ADDR_WIDTH bits of the (optionally dithered) lookup phase.
  logic [LUT_ADDR_WIDTH-1:0] look_hi;

`ifdef DDS_DITHER_EN
  logic [LFSR_W-1:0]      lfsr_q;
  logic [PHASE_WIDTH-1:0] look_sum;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      lfsr_q <= LFSR_SEED;
    end else if (en) begin
      lfsr_q <= {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  assign look_sum = acc_p0 + {{(PHASE_WIDTH-LFSR_W){1'b0}}, lfsr_q};
  assign look_hi  = look_sum[PHASE_WIDTH-1 -: LUT_ADDR_WIDTH];
`else
  assign look_hi  = acc_p0[PHASE_WIDTH-1 -: LUT_ADDR_WIDTH];
`endif

  quad_e             quad_s0;
  logic [ROM_AW-1:0] idx_s0;

  always_comb begin
    quad_s0 = quad_e'(look_hi[LUT_ADDR_WIDTH-1 -: 2]);
    idx_s0  = look_hi[ROM_AW-1:0];
    if (quad_mirrored(quad_s0)) begin
      idx_s0 = ~idx_s0;
    end
  end

  logic [ROM_AW-1:0] idx_p1;
  logic              neg_p1;
  logic              vld_p1;

  // ---- stage S1: quadrant fold ----
  always_ff @(posedge clk) begin
    if (!rstn) begin
      idx_p1 <= '0;
      neg_p1 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      idx_p1 <= idx_s0;
      neg_p1 <= quad_negative(quad_s0);
      vld_p1 <= vld_p0;
    end
  end

  logic [AMP_WIDTH-1:0] rom_p2;
  logic                 neg_p2;
  logic                 vld_p2;

  dds_sine_rom #(
    .FULL_ADDR_W (LUT_ADDR_WIDTH),
    .DATA_W      (AMP_WIDTH),
    .ADDR_W      (ROM_AW)
  ) u_rom (
    .clk  (clk),
    .rstn (rstn),
    .addr (idx_p1),
    .data (rom_p2)
  );

  // ---- stage S2: table read (register inside u_rom) ----
  always_ff @(posedge clk) begin
    if (!rstn) begin
      neg_p2 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      neg_p2 <= neg_p1;
      vld_p2 <= vld_p1;
    end
  end

  logic signed [AMP_WIDTH-1:0] sample_p3;
  logic                        vld_p3;

  // ---- stage S3: sign restore ----
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sample_p3 <= '0;
      vld_p3    <= 1'b0;
    end else begin
      sample_p3 <= apply_sign($signed(rom_p2), neg_p2);
      vld_p3    <= vld_p2;
    end
  end

  assign phase_out    = acc_p0;
  assign fword_active = fword_q;
  assign sample_out   = sample_p3;
  assign sample_valid = vld_p3;

endmodule

// File: tb/tb_dds_phase_gen.sv
// tb_dds_phase_gen: scoreboard bench for dds_phase_gen (default build).
// A reference model of the accumulator and tuning word runs alongside the
// DUT; every enabled step pushes the expected full-wave sine sample, tagged
// with the cycle it must appear on, and the output side pops and compares.
module tb_dds_phase_gen;

  localparam real PI = 3.14159265358979323846;

  logic        clk;
  logic        rstn;
  logic        param_wen;
  logic [31:0] phase_fword;
  logic        en;
  logic        sync_clr;
  logic [31:0] phase_out;
  logic [11:0] sample_out;
  logic        sample_valid;
  logic [31:0] fword_active;

  dds_phase_gen #(
    .PHASE_WIDTH    (32),
    .LUT_ADDR_WIDTH (10),
    .AMP_WIDTH      (12)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .param_wen    (param_wen),
    .phase_fword  (phase_fword),
    .en           (en),
    .sync_clr     (sync_clr),
    .phase_out    (phase_out),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .fword_active (fword_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int due;
    int val;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  int          cyc   = 0;
  logic [31:0] m_acc = '0;
  logic [31:0] m_fw  = '0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Full-wave reference: index the whole period directly, no folding.
  function automatic int exp_sample(input logic [31:0] a);
    int  i;
    real v;
    i = int'(a[31:22]);
    v = 2047.0 * $sin(2.0 * PI * (real'(i) + 0.5) / 1024.0);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  task automatic step();
    logic exp_vld;
    @(posedge clk);
    cyc++;
    if (!rstn) begin
      m_acc = '0;
      m_fw  = '0;
      sb.delete();
    end else begin
      if (sync_clr)  m_acc = '0;
      else if (en)   m_acc = m_acc + m_fw;
      if (en && !sync_clr) sb.push_back('{cyc + 3, exp_sample(m_acc)});
      if (param_wen) m_fw = phase_fword;
    end
    #1;
    check_val("phase_out", phase_out, m_acc);
    check_val("fword_active", fword_active, m_fw);
    exp_vld = (sb.size() > 0) && (sb[0].due == cyc);
    check_val("sample_valid", sample_valid, exp_vld);
    if (exp_vld) begin
      check_val("sample_out", longint'($signed(sample_out)), sb[0].val);
      void'(sb.pop_front());
    end
    if (!rstn) check_val("sample_out_rst", longint'($signed(sample_out)), 0);
  endtask

  task automatic cycle(input logic wen, input logic [31:0] fw, input logic e, input logic clr);
    param_wen   = wen;
    phase_fword = fw;
    en          = e;
    sync_clr    = clr;
    step();
  endtask

  initial begin
    rstn = 1'b0; param_wen = 1'b0; phase_fword = '0; en = 1'b0; sync_clr = 1'b0;
    repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    rstn = 1'b1;

    // Zero tuning word: phase frozen, constant sample 6 keeps flowing.
    repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Quarter-turn steps: 6, 2047, -6, -2047 with wrap back to 0.
    cycle(1'b1, 32'h4000_0000, 1'b0, 1'b0);
    repeat (8) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Word load and enable on the same edge: old word used first.
    cycle(1'b1, 32'h0100_0000, 1'b1, 1'b0);
    repeat (4) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Bring acc to 0x1234_5678 then clear while enabled.
    cycle(1'b1, 32'h1234_5678, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    repeat (4) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Enable gap of five cycles.
    repeat (5) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (5) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      cycle(($urandom_range(0, 7) == 0), $urandom(), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0));
    end

    // Reset in the middle of a stream; nothing stale may appear afterwards.
    cycle(1'b1, 32'h0300_0001, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    rstn = 1'b0;
    repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    rstn = 1'b1;
    repeat (2) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 32'hC000_0000, 1'b1, 1'b0);
    repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Drain.
    repeat (5) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check_val("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
